fft_agu_seq: RTL and testbench

//   Butterfly sequencer for the in-place radix-2 FFT. Generates the level/index pairs

---
 rtl/fft_agu_seq.sv | 155 +++++++++++++++
 tb/tb_fft_agu_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_agu_seq.sv
// +--------------------------------------------------------------------------+
// | fft_agu_seq : radix-2 FFT butterfly sequencer with level-boundary stalls  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module fft_agu_seq #(
  parameter int M        = 9,
  parameter int BFLY_LAT = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  output logic [M-1:0] level_o,
  output logic [M-1:0] index_o,
  output logic         rd_en_o,
  output logic         wr_en_o,
  output logic [M-1:0] wr_level_o,
  output logic [M-1:0] wr_index_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int                IW       = M - 1;
  localparam int                CW       = $clog2(BFLY_LAT + 1);
  localparam logic [IW-1:0]     IDX_LAST = '1;
  localparam logic [M-1:0]      LVL_LAST = M'(M - 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(BFLY_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q;
  logic [M-1:0]  level_q;
  logic [IW-1:0] index_q;
  logic [CW-1:0] cnt_q;
  logic          rd_en_q;
  logic          busy_q;
  logic          done_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      level_q <= '0;
      index_q <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          level_q <= '0;
          index_q <= '0;
          cnt_q   <= '0;
          if (start_i) begin
            state_q <= S_RUN;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (index_q == IDX_LAST) begin
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            if (level_q == LVL_LAST) begin
              state_q <= S_DRAIN;
            end else begin
              // Advance the level now so STALL already presents the next level.
              state_q <= S_STALL;
              level_q <= level_q + 1'b1;
              index_q <= '0;
            end
          end else begin
            index_q <= index_q + 1'b1;
          end
        end
        S_STALL: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= S_RUN;
            rd_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            level_q <= '0;
            index_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write-back delay line; payload only advances with a valid beat so the tail holds.
  logic [BFLY_LAT-1:0] vld_q;
  logic [M-1:0]        lvl_q [BFLY_LAT];
  logic [IW-1:0]       idx_q [BFLY_LAT];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q <= '0;
      for (int k = 0; k < BFLY_LAT; k++) begin
        lvl_q[k] <= '0;
        idx_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= rd_en_q;
      if (rd_en_q) begin
        lvl_q[0] <= level_q;
        idx_q[0] <= index_q;
      end
      for (int k = 1; k < BFLY_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          lvl_q[k] <= lvl_q[k-1];
          idx_q[k] <= idx_q[k-1];
        end
      end
    end
  end

  assign level_o    = level_q;
  assign index_o    = {1'b0, index_q};
  assign rd_en_o    = rd_en_q;
  assign wr_en_o    = vld_q[BFLY_LAT-1];
  assign wr_level_o = lvl_q[BFLY_LAT-1];
  assign wr_index_o = {1'b0, idx_q[BFLY_LAT-1]};
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_agu_seq.sv
// Testbench for fft_agu_seq: table vectors, directed corner sequences, random starts/resets vs. a timing model.
`default_nettype none

module tb_fft_agu_seq;

  typedef struct {
    bit rd, wr, busy, done;
    int lvl, idx, wl, wi;
  } out_t;

  typedef struct {
    int   cyc;
    bit   st;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, st_a = 1'b0;
  logic [2:0] lv_a, ix_a, wl_a, wi_a;
  logic       rd_a, wr_a, bz_a, dn_a;
  logic       rst_b = 1'b1, st_b = 1'b0;
  logic [2:0] lv_b, ix_b, wl_b, wi_b;
  logic       rd_b, wr_b, bz_b, dn_b;
  logic       rst_c = 1'b1, st_c = 1'b0;
  logic [8:0] lv_c, ix_c, wl_c, wi_c;
  logic       rd_c, wr_c, bz_c, dn_c;

  fft_agu_seq #(.M(3), .BFLY_LAT(2)) u_a (
    .clk_i(clk), .reset_i(rst_a), .start_i(st_a), .level_o(lv_a), .index_o(ix_a),
    .rd_en_o(rd_a), .wr_en_o(wr_a), .wr_level_o(wl_a), .wr_index_o(wi_a),
    .busy_o(bz_a), .done_o(dn_a));
  fft_agu_seq #(.M(3), .BFLY_LAT(1)) u_b (
    .clk_i(clk), .reset_i(rst_b), .start_i(st_b), .level_o(lv_b), .index_o(ix_b),
    .rd_en_o(rd_b), .wr_en_o(wr_b), .wr_level_o(wl_b), .wr_index_o(wi_b),
    .busy_o(bz_b), .done_o(dn_b));
  fft_agu_seq #(.M(9), .BFLY_LAT(2)) u_c (
    .clk_i(clk), .reset_i(rst_c), .start_i(st_c), .level_o(lv_c), .index_o(ix_c),
    .rd_en_o(rd_c), .wr_en_o(wr_c), .wr_level_o(wl_c), .wr_index_o(wi_c),
    .busy_o(bz_c), .done_o(dn_c));

  int   n_tests = 0;
  int   n_fail  = 0;
  int   sel     = 0;
  int   mM = 3, mL = 2, mt = 0, hl = 0, hi = 0;
  out_t ob, ex;
  vec_t tbl[$];

  function automatic bit eq(out_t a, out_t b);
    return a.rd == b.rd && a.wr == b.wr && a.busy == b.busy && a.done == b.done &&
           a.lvl == b.lvl && a.idx == b.idx && a.wl == b.wl && a.wi == b.wi;
  endfunction

  function automatic string fmt(out_t a);
    return $sformatf("rd=%0b wr=%0b busy=%0b done=%0b lvl=%0d idx=%0d wl=%0d wi=%0d",
                     a.rd, a.wr, a.busy, a.done, a.lvl, a.idx, a.wl, a.wi);
  endfunction

  function automatic out_t mk(bit rd, bit wr, bit busy, bit done, int lvl, int idx, int wl, int wi);
    out_t o;
    o.rd = rd; o.wr = wr; o.busy = busy; o.done = done;
    o.lvl = lvl; o.idx = idx; o.wl = wl; o.wi = wi;
    return o;
  endfunction

  // Expected outputs from the pass timeline: mt = cycles since the start edge (0 = idle).
  function automatic out_t model_out(int m, int l, int t, int h_l, int h_i);
    int h, p, lev, off, s;
    out_t o;
    h = 1 << (m - 1);
    p = h + l;
    o = mk(0, 0, 0, 0, 0, 0, h_l, h_i);
    if (t >= 1 && t <= m * p) begin
      o.busy = 1;
      lev = (t - 1) / p;
      off = (t - 1) % p;
      if (off < h) begin
        o.rd = 1; o.lvl = lev; o.idx = off;
      end else if (lev < m - 1) begin
        o.lvl = lev + 1; o.idx = 0;
      end else begin
        o.lvl = m - 1; o.idx = h - 1;
      end
    end
    if (t == m * p + 1) o.done = 1;
    s = t - l;
    if (t >= 1 && s >= 1 && s <= m * p && ((s - 1) % p) < h) begin
      o.wr = 1; o.wl = (s - 1) / p; o.wi = (s - 1) % p;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input bit ok, input string act, input string req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", nm, act, req);
    end
  endtask

  task automatic sample();
    case (sel)
      0: ob = mk(rd_a, wr_a, bz_a, dn_a, int'(lv_a), int'(ix_a), int'(wl_a), int'(wi_a));
      1: ob = mk(rd_b, wr_b, bz_b, dn_b, int'(lv_b), int'(ix_b), int'(wl_b), int'(wi_b));
      default: ob = mk(rd_c, wr_c, bz_c, dn_c, int'(lv_c), int'(ix_c), int'(wl_c), int'(wi_c));
    endcase
  endtask

  // Drive one cycle of inputs, advance the model, sample at the falling edge and compare.
  task automatic step(input logic r, input logic s);
    int p;
    case (sel)
      0: begin rst_a = r; st_a = s; end
      1: begin rst_b = r; st_b = s; end
      default: begin rst_c = r; st_c = s; end
    endcase
    @(posedge clk);
    p = (1 << (mM - 1)) + mL;
    if (r) begin
      mt = 0; hl = 0; hi = 0;
    end else if (mt == 0 || mt == mM * p + 1) begin
      mt = s ? 1 : 0;
    end else begin
      mt++;
    end
    ex = model_out(mM, mL, mt, hl, hi);
    if (ex.wr) begin hl = ex.wl; hi = ex.wi; end
    @(negedge clk);
    sample();
    chk("model", eq(ob, ex), fmt(ob), fmt(ex));
  endtask

  task automatic run_table(input string tag);
    for (int c = 1; c <= 22; c++) begin
      bit s;
      s = 0;
      foreach (tbl[i]) if (tbl[i].cyc == c) s = tbl[i].st;
      step(1'b0, s);
      foreach (tbl[i])
        if (tbl[i].cyc == c)
          chk($sformatf("%s_c%0d", tag, c), eq(ob, tbl[i].o), fmt(ob), fmt(tbl[i].o));
    end
  endtask

  task automatic add(input int c, input bit st, input out_t o);
    vec_t v;
    v.cyc = c; v.st = st; v.o = o;
    tbl.push_back(v);
  endtask

  initial begin
    int first_rd[3], last_wr[3], nd, done_at, nwr, nrd, k;
    bit bad, rd20, prv_rd;
    int prv_l, prv_i;

    //  cyc  st      rd wr bz dn lvl idx wl wi
    add(1,  1, mk(1, 0, 1, 0, 0, 0, 0, 0));
    add(3,  0, mk(1, 1, 1, 0, 0, 2, 0, 0));
    add(4,  0, mk(1, 1, 1, 0, 0, 3, 0, 1));
    add(5,  0, mk(0, 1, 1, 0, 1, 0, 0, 2));
    add(6,  0, mk(0, 1, 1, 0, 1, 0, 0, 3));
    add(7,  0, mk(1, 0, 1, 0, 1, 0, 0, 3));
    add(9,  0, mk(1, 1, 1, 0, 1, 2, 1, 0));
    add(12, 0, mk(0, 1, 1, 0, 2, 0, 1, 3));
    add(13, 0, mk(1, 0, 1, 0, 2, 0, 1, 3));
    add(16, 0, mk(1, 1, 1, 0, 2, 3, 2, 1));
    add(17, 0, mk(0, 1, 1, 0, 2, 3, 2, 2));
    add(18, 0, mk(0, 1, 1, 0, 2, 3, 2, 3));
    add(19, 0, mk(0, 0, 0, 1, 0, 0, 2, 3));
    add(20, 0, mk(0, 0, 0, 0, 0, 0, 2, 3));

    @(negedge clk);
    sel = 0; mM = 3; mL = 2;
    step(1, 0); step(1, 0);
    chk("reset_state", eq(ob, mk(0, 0, 0, 0, 0, 0, 0, 0)), fmt(ob), "all zero");
    step(0, 0);

    // Single pass, checked against the table and for the level hazard ordering.
    foreach (first_rd[i]) begin first_rd[i] = -1; last_wr[i] = -1; end
    bad = 0;
    for (int c = 1; c <= 22; c++) begin
      bit s;
      s = 0;
      foreach (tbl[i]) if (tbl[i].cyc == c) s = tbl[i].st;
      step(1'b0, s);
      foreach (tbl[i])
        if (tbl[i].cyc == c)
          chk($sformatf("vec_c%0d", c), eq(ob, tbl[i].o), fmt(ob), fmt(tbl[i].o));
      if (ob.rd && ob.lvl < 3 && first_rd[ob.lvl] < 0) first_rd[ob.lvl] = c;
      if (ob.wr && ob.wl < 3) last_wr[ob.wl] = c;
      if ((ob.rd || ob.wr) && !ob.busy) bad = 1;
      if (ob.done && ob.busy) bad = 1;
    end
    for (int l = 0; l < 2; l++)
      chk($sformatf("hazard_L%0d", l), last_wr[l] + 1 == first_rd[l + 1],
          $sformatf("last_wr=%0d first_rd_next=%0d", last_wr[l], first_rd[l + 1]),
          "last_wr+1 == first_rd_next");
    chk("busy_cover", !bad, $sformatf("violation=%0b", bad), "violation=0");

    // Start held high: re-starts ignored mid-pass, next pass from the DONE cycle.
    step(1, 0); step(0, 0);
    nd = 0; done_at = -1; rd20 = 0;
    for (int c = 1; c <= 26; c++) begin
      step(0, 1);
      if (ob.done) begin nd++; if (done_at < 0) done_at = c; end
      if (c == 20) rd20 = ob.rd && ob.lvl == 0 && ob.idx == 0;
    end
    chk("held_start_done", nd == 1 && done_at == 19,
        $sformatf("done_count=%0d first_done=%0d", nd, done_at), "done_count=1 first_done=19");
    chk("held_start_restart", rd20, $sformatf("rd_c20=%0b", rd20), "rd_c20=1 at L0 i0");

    // Reset mid level 1: no escaping write-backs, then a clean replay.
    step(1, 0); step(0, 0);
    nwr = 0;
    for (int c = 1; c <= 14; c++) begin
      step(c == 9, c == 1);
      if (c == 9)
        chk("midreset_zero", eq(ob, mk(0, 0, 0, 0, 0, 0, 0, 0)), fmt(ob), "all zero");
      if (c >= 9 && c <= 12 && ob.wr) nwr++;
    end
    chk("midreset_no_wr", nwr == 0, $sformatf("wr_count=%0d", nwr), "wr_count=0");
    run_table("replay");

    // Random start pulses and occasional resets against the model.
    step(1, 0);
    for (int c = 0; c < 600; c++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0);

    // BFLY_LAT=1: single-cycle stall and one-cycle write delay.
    sel = 1; mM = 3; mL = 1;
    step(1, 0); step(1, 0); step(0, 0);
    done_at = -1; bad = 0; prv_rd = 0; prv_l = 0; prv_i = 0;
    for (int c = 1; c <= 20; c++) begin
      step(0, c == 1);
      if (ob.done && done_at < 0) done_at = c;
      if (ob.wr != prv_rd || (ob.wr && (ob.wl != prv_l || ob.wi != prv_i))) bad = 1;
      prv_rd = ob.rd; prv_l = ob.lvl; prv_i = ob.idx;
    end
    chk("lat1_done_cycle", done_at == 16, $sformatf("done_at=%0d", done_at), "done_at=16");
    chk("lat1_wr_delay", !bad, $sformatf("violation=%0b", bad), "violation=0");

    // Full-size pass.
    sel = 2; mM = 9; mL = 2;
    step(1, 0); step(1, 0); step(0, 0);
    nrd = 0; nwr = 0; done_at = -1; bad = 0; k = 0;
    for (int c = 1; c <= 2330; c++) begin
      step(0, c == 1);
      if (ix_c[8] !== 1'b0 || wi_c[8] !== 1'b0) bad = 1;
      if (ob.rd) begin
        if (ob.lvl != k / 256 || ob.idx != k % 256) bad = 1;
        k++; nrd++;
      end
      if (ob.wr) nwr++;
      if (ob.done && done_at < 0) done_at = c;
    end
    chk("m9_rd_count", nrd == 2304, $sformatf("%0d", nrd), "2304");
    chk("m9_wr_count", nwr == 2304, $sformatf("%0d", nwr), "2304");
    chk("m9_done_cycle", done_at == 2323, $sformatf("%0d", done_at), "2323");
    chk("m9_order_msb", !bad, $sformatf("violation=%0b", bad), "violation=0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
